// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-to-read bypass and a per-register
// pending-load scoreboard. Sits between decode and execute; raises stall while
// a consumed source operand still waits on an in-flight load.
module regfile_scoreboard #(
    parameter int WIDTH    = 16,
    parameter int NREGS    = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [AW-1:0]    rr1,
    input  logic [AW-1:0]    rr2,
    input  logic             use1,
    input  logic             use2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             regwrite,
    input  logic [AW-1:0]    wr,
    input  logic [WIDTH-1:0] wd,
    input  logic             issue,
    input  logic [AW-1:0]    issue_reg,
    output logic             stall,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      pend_count,
    output logic             issue_err
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             write_ok;
    logic             issue_ok;
    logic             fwd1;
    logic             fwd2;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      count_next;

    // Qualify writes and issues: register 0 is hard-wired when ZERO_REG is set,
    // and nothing is accepted while reset is held (so reads stay at 0 then).
    always_comb begin
        write_ok = reset_n && regwrite && !((ZERO_REG != 0) && (wr == '0));
        issue_ok = reset_n && issue && !((ZERO_REG != 0) && (issue_reg == '0));
        fwd1     = (BYPASS != 0) && write_ok && (wr == rr1);
        fwd2     = (BYPASS != 0) && write_ok && (wr == rr2);
    end

    // Combinational read ports with optional same-cycle forwarding of write data.
    always_comb begin
        rd1 = regs[rr1];
        rd2 = regs[rr2];
        if ((ZERO_REG != 0) && (rr1 == '0)) rd1 = '0;
        if ((ZERO_REG != 0) && (rr2 == '0)) rd2 = '0;
        if (fwd1) rd1 = wd;
        if (fwd2) rd2 = wd;
    end

    // A consumed operand stalls while its register is pending, unless the
    // clearing writeback is being forwarded this very cycle.
    always_comb begin
        stall = (use1 && busy[rr1] && !fwd1) || (use2 && busy[rr2] && !fwd2);
    end

    // Next scoreboard vector: writeback clears, a new issue sets (issue wins on collision).
    always_comb begin
        busy_next = busy;
        if (write_ok) busy_next[wr] = 1'b0;
        if (issue_ok) busy_next[issue_reg] = 1'b1;
        count_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_next = count_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    // Register storage; async reset clears every entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (write_ok) begin
            regs[wr] <= wd;
        end
    end

    // Scoreboard state, pending count and the double-issue error pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            pend_count <= '0;
            issue_err  <= 1'b0;
        end else begin
            busy       <= busy_next;
            pend_count <= count_next;
            issue_err  <= issue_ok && busy[issue_reg];
        end
    end

endmodule
